fifo_ctrl: RTL and testbench

- Synchronous first-word-fall-through FIFO controller that owns the read/write pointers for an external simple dual-port RAM.
- The RAM has a synchronous write and a combinational (asynchronous) read.
- Sits directly upstream of that RAM: drives its write address, read address, write enable and write data, and consumes its read data.
- Presents a valid/full/empty queue interface to producer and consumer logic, e.g. a UART RX feeding a display or TX path.

---
 rtl/fifo_ctrl_pkg.sv | 9 +
 rtl/fifo_ptr.sv | 21 ++
 rtl/fifo_ctrl.sv | 77 +++++++
 tb/tb_fifo_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared sizing for the FWFT FIFO controller and its pointer sub-module.
package fifo_ctrl_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_BITS  = 8;
  localparam int unsigned DEF_DEPTH      = 2 ** DEF_ADDR_BITS;
  localparam int unsigned DEF_PTR_W      = DEF_ADDR_BITS + 1;

endpackage

// File: rtl/fifo_ptr.sv
// Pointer register with increment enable; the MSB acts as the wrap bit.
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned PTR_W = DEF_PTR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// First-word-fall-through FIFO controller driving an external dual-port RAM
// with synchronous write and combinational read.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic [ADDR_BITS:0]    count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_we,
  output logic [ADDR_BITS-1:0]  ram_wa,
  output logic [ADDR_BITS-1:0]  ram_ra,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int unsigned PTR_W = ADDR_BITS + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (wr_acc),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (rd_acc),
    .ptr (rd_ptr)
  );

  // Status depends only on the pointer registers, never on the requests.
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[ADDR_BITS-1:0] == rd_ptr[ADDR_BITS-1:0]) &&
            (wr_ptr[ADDR_BITS] != rd_ptr[ADDR_BITS]);
    count = wr_ptr - rd_ptr;
  end

  always_comb begin
    wr_acc  = wr_en & ~full;
    rd_acc  = rd_en & ~empty;
    ram_we  = wr_acc & ~rst;
    ram_wa  = wr_ptr[ADDR_BITS-1:0];
    ram_ra  = rd_ptr[ADDR_BITS-1:0];
    ram_din = wr_data;
    rd_data = ram_dout;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench: a queue-based FIFO model predicts per-cycle status and
// head data; a negedge monitor compares the DUT against those predictions.
module tb_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AB    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full, empty, overflow, underflow, ram_we;
  logic [DW-1:0] rd_data, ram_din, ram_dout;
  logic [AB:0]   count;
  logic [AB-1:0] ram_wa, ram_ra;

  logic [DW-1:0] mem [DEPTH];

  always #5 clk = ~clk;

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .ram_we    (ram_we),
    .ram_wa    (ram_wa),
    .ram_ra    (ram_ra),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  // Simple dual-port RAM: synchronous write, combinational read.
  always @(posedge clk) if (ram_we) mem[ram_wa] <= ram_din;
  assign ram_dout = mem[ram_ra];

  typedef struct {
    int          count;
    bit          empty;
    bit          full;
    bit          ov;
    bit          un;
    bit          we;
    int          wa;
    int          ra;
    bit          has_data;
    bit [DW-1:0] data;
  } exp_t;

  exp_t        eq[$];
  bit [DW-1:0] mq[$];
  bit          m_ov, m_un;
  int          m_wp, m_rp;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (eq.size() > 0) begin
      exp_t e;
      e = eq.pop_front();
      chk("count",     32'(count),     32'(e.count));
      chk("empty",     32'(empty),     32'(e.empty));
      chk("full",      32'(full),      32'(e.full));
      chk("overflow",  32'(overflow),  32'(e.ov));
      chk("underflow", 32'(underflow), 32'(e.un));
      chk("ram_we",    32'(ram_we),    32'(e.we));
      chk("ram_wa",    32'(ram_wa),    32'(e.wa));
      chk("ram_ra",    32'(ram_ra),    32'(e.ra));
      if (e.we) chk("ram_din", 32'(ram_din), 32'(wr_data));
      if (e.has_data) chk("rd_data", 32'(rd_data), 32'(e.data));
    end
  end

  // Drive one cycle and predict what the monitor should see this cycle.
  task automatic cyc(input bit r, input bit we, input bit re, input bit [DW-1:0] d);
    exp_t e;
    int   n;
    bit   wacc, racc;
    @(posedge clk);
    #1;
    rst = r; wr_en = we; rd_en = re; wr_data = d;
    if (r) begin
      mq.delete(); m_ov = 0; m_un = 0; m_wp = 0; m_rp = 0;
    end
    n = mq.size();
    e.count    = n;
    e.empty    = (n == 0);
    e.full     = (n == DEPTH);
    e.ov       = m_ov;
    e.un       = m_un;
    e.we       = !r && we && (n < DEPTH);
    e.wa       = m_wp % DEPTH;
    e.ra       = m_rp % DEPTH;
    e.has_data = (n != 0);
    e.data     = (n != 0) ? mq[0] : '0;
    eq.push_back(e);
    if (!r) begin
      wacc = we && (n < DEPTH);
      racc = re && (n > 0);
      if (we && n == DEPTH) m_ov = 1;
      if (re && n == 0)     m_un = 1;
      if (racc) begin void'(mq.pop_front()); m_rp = (m_rp + 1) % (2 * DEPTH); end
      if (wacc) begin mq.push_back(d);       m_wp = (m_wp + 1) % (2 * DEPTH); end
    end
  endtask

  task automatic wr(input bit [DW-1:0] d); cyc(0, 1, 0, d); endtask
  task automatic rd();                     cyc(0, 0, 1, '0); endtask
  task automatic idle();                   cyc(0, 0, 0, '0); endtask

  initial begin
    int guard;
    m_ov = 0; m_un = 0; m_wp = 0; m_rp = 0;
    cyc(1, 0, 0, '0);
    cyc(1, 1, 1, 8'h77);
    idle();

    // Fill to full, then an overflowing write.
    wr(8'hA1); wr(8'hB2); wr(8'hC3); wr(8'hD4);
    wr(8'hEE);
    idle();

    // Drain in order, then an underflowing read.
    rd(); rd(); rd(); rd();
    rd();
    idle();

    // Wrap-around.
    for (int i = 0; i < 3; i++) wr(8'h10 + 8'(i));
    for (int i = 0; i < 3; i++) rd();
    for (int i = 0; i < 3; i++) wr(8'h20 + 8'(i));
    idle();
    for (int i = 0; i < 3; i++) rd();

    // Simultaneous push/pop at count 2, at full and at empty.
    cyc(1, 0, 0, '0);
    wr(8'h31); wr(8'h32);
    for (int i = 0; i < 10; i++) cyc(0, 1, 1, 8'($urandom));
    wr(8'h41); wr(8'h42);
    cyc(0, 1, 1, 8'h99);
    rd(); rd(); rd();
    cyc(0, 1, 1, 8'h5A);
    idle();

    // Reset mid-stream, then a fresh write is read back.
    cyc(1, 0, 0, '0);
    wr(8'h61); wr(8'h62); wr(8'h63);
    cyc(1, 1, 1, 8'h64);
    wr(8'h55);
    rd();
    idle();

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 60) == 0), 1'($urandom), 1'($urandom), 8'($urandom));
    end
    idle();

    guard = 0;
    while (eq.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (eq.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations left, want 0", eq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
